// File: rtl/bsg_cache_to_dram_ctrl_rx.sv
// Read-return path: buffers app_rd_* words and steers each block to the issuing cache in request order.
// Optional protocol checker and sticky error_o enabled by defining BSG_CACHE_TO_DRAM_CTRL_RX_ERR_EN.
module bsg_cache_to_dram_ctrl_rx #(
  parameter int num_cache_p           = 2,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 4,
  parameter int tag_fifo_els_p        = 8,
  parameter int data_fifo_els_p       = 8,
  localparam int lg_num_cache_lp      = (num_cache_p > 1) ? $clog2(num_cache_p) : 1
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                v_i,
  input  logic [lg_num_cache_lp-1:0]          tag_i,
  output logic                                ready_o,
  input  logic                                app_rd_data_valid_i,
  input  logic [data_width_p-1:0]             app_rd_data_i,
  input  logic                                app_rd_data_end_i,
  output logic [num_cache_p*data_width_p-1:0] dma_data_o,
  output logic [num_cache_p-1:0]              dma_data_v_o,
  input  logic [num_cache_p-1:0]              dma_data_ready_i,
  output logic                                error_o
);

  localparam int TPW = (tag_fifo_els_p > 1) ? $clog2(tag_fifo_els_p) : 1;
  localparam int TCW = $clog2(tag_fifo_els_p + 1);
  localparam int DPW = (data_fifo_els_p > 1) ? $clog2(data_fifo_els_p) : 1;
  localparam int DCW = $clog2(data_fifo_els_p + 1);
  localparam int CW  = $clog2(data_fifo_els_p + 1);
  localparam int WCW = (block_size_in_words_p > 1) ? $clog2(block_size_in_words_p) : 1;

  logic [lg_num_cache_lp-1:0] tag_mem_q [tag_fifo_els_p];
  logic [data_width_p-1:0]    data_mem_q [data_fifo_els_p];

  logic [TPW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [TCW-1:0] tag_cnt_q, tag_cnt_d;
  logic [DPW-1:0] data_wr_q, data_wr_d, data_rd_q, data_rd_d;
  logic [DCW-1:0] data_cnt_q, data_cnt_d;
  logic [CW-1:0]  credit_q, credit_d;
  logic [WCW-1:0] out_cnt_q, out_cnt_d;
  logic           ready_en_q, ready_en_d;

  logic                       tag_v, tag_full, data_empty, data_full;
  logic                       accept, deliver, last_word, data_push;
  logic [lg_num_cache_lp-1:0] tag_head;
  logic [data_width_p-1:0]    data_head;

  function automatic logic [TPW-1:0] tag_inc(input logic [TPW-1:0] p);
    return (p == TPW'(tag_fifo_els_p - 1)) ? '0 : p + TPW'(1);
  endfunction

  function automatic logic [DPW-1:0] data_inc(input logic [DPW-1:0] p);
    return (p == DPW'(data_fifo_els_p - 1)) ? '0 : p + DPW'(1);
  endfunction

  // ready_en_q holds ready_o low during reset and for the first cycle after release
  always_comb begin
    tag_v      = (tag_cnt_q != '0);
    tag_full   = (tag_cnt_q == TCW'(tag_fifo_els_p));
    data_empty = (data_cnt_q == '0);
    data_full  = (data_cnt_q == DCW'(data_fifo_els_p));
    tag_head   = tag_mem_q[tag_rd_q];
    data_head  = data_mem_q[data_rd_q];
    ready_o    = ready_en_q & ~tag_full & (credit_q >= CW'(block_size_in_words_p));
    accept     = v_i & ready_o;
    data_push  = app_rd_data_valid_i & ~data_full;
    ready_en_d = 1'b1;
  end

  always_comb begin
    dma_data_v_o = '0;
    if (tag_v && !data_empty) dma_data_v_o[tag_head] = 1'b1;
    dma_data_o = {num_cache_p{data_head}};
    deliver    = |(dma_data_v_o & dma_data_ready_i);
    last_word  = deliver & (out_cnt_q == WCW'(block_size_in_words_p - 1));
  end

  always_comb begin
    tag_wr_d  = accept    ? tag_inc(tag_wr_q)   : tag_wr_q;
    tag_rd_d  = last_word ? tag_inc(tag_rd_q)   : tag_rd_q;
    tag_cnt_d = tag_cnt_q + TCW'(accept) - TCW'(last_word);

    data_wr_d  = data_push ? data_inc(data_wr_q) : data_wr_q;
    data_rd_d  = deliver   ? data_inc(data_rd_q) : data_rd_q;
    data_cnt_d = data_cnt_q + DCW'(data_push) - DCW'(deliver);

    credit_d = credit_q - (accept ? CW'(block_size_in_words_p) : '0) + CW'(deliver);

    out_cnt_d = out_cnt_q;
    if (deliver) out_cnt_d = last_word ? '0 : out_cnt_q + WCW'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      tag_cnt_q  <= '0;
      data_wr_q  <= '0;
      data_rd_q  <= '0;
      data_cnt_q <= '0;
      credit_q   <= CW'(data_fifo_els_p);
      out_cnt_q  <= '0;
      ready_en_q <= 1'b0;
    end else begin
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      tag_cnt_q  <= tag_cnt_d;
      data_wr_q  <= data_wr_d;
      data_rd_q  <= data_rd_d;
      data_cnt_q <= data_cnt_d;
      credit_q   <= credit_d;
      out_cnt_q  <= out_cnt_d;
      ready_en_q <= ready_en_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept)    tag_mem_q[tag_wr_q]   <= tag_i;
    if (data_push) data_mem_q[data_wr_q] <= app_rd_data_i;
  end

`ifdef BSG_CACHE_TO_DRAM_CTRL_RX_ERR_EN
  logic [WCW-1:0] in_cnt_q, in_cnt_d;
  logic           error_q, error_d;

  always_comb begin
    in_cnt_d = in_cnt_q;
    if (data_push) in_cnt_d = (in_cnt_q == WCW'(block_size_in_words_p - 1)) ? '0 : in_cnt_q + WCW'(1);
    error_d = error_q;
    if (app_rd_data_valid_i) begin
      if (data_full) error_d = 1'b1;
      if (app_rd_data_end_i != (in_cnt_q == WCW'(block_size_in_words_p - 1))) error_d = 1'b1;
      if (!tag_v && !accept) error_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      in_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      in_cnt_q <= in_cnt_d;
      error_q  <= error_d;
    end
  end

  assign error_o = error_q;
`else
  logic unused_end;
  assign unused_end = app_rd_data_end_i;
  assign error_o    = 1'b0;
`endif

endmodule
